// File: rtl/pc_stack_unit.sv
// Program counter with a return-address stack: absolute jump, relative branch,
// sequential increment, call/ret with sticky overflow/underflow error flags.
module pc_stack_unit #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned RESET_VEC = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       load_pc,
  input  logic                       inc_pc,
  input  logic                       branch_rel,
  input  logic                       call,
  input  logic                       ret,
  input  logic [WIDTH-1:0]           pc_in,
  input  logic [WIDTH-1:0]           offset,
  output logic [WIDTH-1:0]           pc_out,
  output logic [$clog2(DEPTH+1)-1:0] sp,
  output logic                       stack_full,
  output logic                       stack_empty,
  output logic                       overflow_err,
  output logic                       underflow_err
);

  localparam int unsigned SP_W  = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_VEC);
  localparam logic [SP_W-1:0]  SP_MAX = SP_W'(DEPTH);
  localparam logic [SP_W-1:0]  SP_ONE = SP_W'(1);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [SP_W-1:0]  sp_q, sp_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];

  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [SP_W-1:0]  sp_dec;
  logic             is_full;
  logic             is_empty;

  assign is_full  = (sp_q == SP_MAX);
  assign is_empty = (sp_q == '0);
  assign sp_dec   = sp_q - SP_ONE;
  assign wr_idx   = IDX_W'(sp_q);
  assign rd_idx   = IDX_W'(sp_dec);

  // Priority chain; a rejected call/ret still consumes the cycle so nothing
  // lower in the chain can act on the same edge.
  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    stack_d = stack_q;
    if (!reset && !stall) begin
      if (ret) begin
        if (is_empty) begin
          unf_d = 1'b1;
        end else begin
          pc_d = stack_q[rd_idx];
          sp_d = sp_dec;
        end
      end else if (call) begin
        if (is_full) begin
          ovf_d = 1'b1;
        end else begin
          stack_d[wr_idx] = pc_q + WIDTH'(1);
          sp_d            = sp_q + SP_ONE;
          pc_d            = pc_in;
        end
      end else if (load_pc) begin
        pc_d = pc_in;
      end else if (branch_rel) begin
        pc_d = pc_q + offset;
      end else if (inc_pc) begin
        pc_d = pc_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RST_PC;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Entries are only readable below sp, so they never need clearing.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign pc_out        = pc_q;
  assign sp            = sp_q;
  assign stack_full    = is_full;
  assign stack_empty   = is_empty;
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit (WIDTH=8, DEPTH=4, RESET_VEC=0).
module tb_pc_stack_unit;

  logic       clk;
  logic       reset;
  logic       stall;
  logic       load_pc;
  logic       inc_pc;
  logic       branch_rel;
  logic       call;
  logic       ret;
  logic [7:0] pc_in;
  logic [7:0] offset;
  logic [7:0] pc_out;
  logic [2:0] sp;
  logic       stack_full;
  logic       stack_empty;
  logic       overflow_err;
  logic       underflow_err;

  int checks;
  int errors;

  pc_stack_unit #(.WIDTH(8), .DEPTH(4), .RESET_VEC(0)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .load_pc       (load_pc),
    .inc_pc        (inc_pc),
    .branch_rel    (branch_rel),
    .call          (call),
    .ret           (ret),
    .pc_in         (pc_in),
    .offset        (offset),
    .pc_out        (pc_out),
    .sp            (sp),
    .stack_full    (stack_full),
    .stack_empty   (stack_empty),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs at negedge, then sample #1 after the rising edge.
  task automatic cycle(input logic rst, input logic st, input logic ld,
                       input logic inc, input logic br, input logic cl,
                       input logic rt, input logic [7:0] pin,
                       input logic [7:0] off);
    @(negedge clk);
    reset = rst; stall = st; load_pc = ld; inc_pc = inc;
    branch_rel = br; call = cl; ret = rt; pc_in = pin; offset = off;
    @(posedge clk);
    #1;
    reset = 1'b0; stall = 1'b0; load_pc = 1'b0; inc_pc = 1'b0;
    branch_rel = 1'b0; call = 1'b0; ret = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [7:0] exp_pc,
                             input logic [2:0] exp_sp, input logic exp_ovf,
                             input logic exp_unf);
    check({tag, "_pc"}, 32'(pc_out), 32'(exp_pc));
    check({tag, "_sp"}, 32'(sp), 32'(exp_sp));
    check({tag, "_full"}, 32'(stack_full), 32'(exp_sp == 3'd4));
    check({tag, "_empty"}, 32'(stack_empty), 32'(exp_sp == 3'd0));
    check({tag, "_ovf"}, 32'(overflow_err), 32'(exp_ovf));
    check({tag, "_unf"}, 32'(underflow_err), 32'(exp_unf));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0; stall = 1'b0; load_pc = 1'b0; inc_pc = 1'b0;
    branch_rel = 1'b0; call = 1'b0; ret = 1'b0; pc_in = '0; offset = '0;

    // reset state
    cycle(1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    check_state("reset", 8'h00, 3'd0, 0, 0);

    // 256 increments wrap back to zero
    for (int i = 1; i <= 256; i++) begin
      cycle(0, 0, 0, 1, 0, 0, 0, 8'h00, 8'h00);
      check("inc_pc", 32'(pc_out), 32'(i % 256));
    end
    check_state("inc_wrap", 8'h00, 3'd0, 0, 0);

    // idle hold
    cycle(0, 0, 0, 0, 0, 0, 0, 8'h55, 8'h55);
    check_state("idle", 8'h00, 3'd0, 0, 0);

    // relative branches, negative then positive
    cycle(0, 0, 1, 0, 0, 0, 0, 8'h10, 8'h00);
    check("load", 32'(pc_out), 32'h10);
    cycle(0, 0, 0, 0, 1, 0, 0, 8'h00, 8'hFC);
    check("br_neg", 32'(pc_out), 32'h0C);
    cycle(0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h05);
    check("br_pos", 32'(pc_out), 32'h11);

    // nested call/ret
    cycle(0, 0, 1, 0, 0, 0, 0, 8'h20, 8'h00);
    cycle(0, 0, 0, 0, 0, 1, 0, 8'h80, 8'h00);
    check_state("call1", 8'h80, 3'd1, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 0, 8'hA0, 8'h00);
    check_state("call2", 8'hA0, 3'd2, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00);
    check_state("ret1", 8'h81, 3'd1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00);
    check_state("ret2", 8'h21, 3'd0, 0, 0);

    // fill to overflow from pc=0x21
    cycle(0, 0, 0, 0, 0, 1, 0, 8'h10, 8'h00);
    check_state("fill1", 8'h10, 3'd1, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 0, 8'h20, 8'h00);
    check_state("fill2", 8'h20, 3'd2, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 0, 8'h30, 8'h00);
    check_state("fill3", 8'h30, 3'd3, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 0, 8'h40, 8'h00);
    check_state("fill4", 8'h40, 3'd4, 0, 0);
    cycle(0, 0, 0, 1, 0, 1, 0, 8'h50, 8'h00);
    check_state("overflow", 8'h40, 3'd4, 1, 0);

    // drain in reverse order, then underflow with inc also requested
    cycle(0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00);
    check_state("drain1", 8'h31, 3'd3, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00);
    check_state("drain2", 8'h21, 3'd2, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00);
    check_state("drain3", 8'h11, 3'd1, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00);
    check_state("drain4", 8'h22, 3'd0, 1, 0);
    cycle(0, 0, 0, 1, 0, 0, 1, 8'h00, 8'h00);
    check_state("underflow", 8'h22, 3'd0, 1, 1);

    // stall freezes everything; releasing it lets ret win
    cycle(1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    check_state("reset2", 8'h00, 3'd0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0, 0, 8'h33, 8'h00);
    cycle(0, 1, 1, 1, 1, 1, 1, 8'h99, 8'h01);
    check_state("stall_all", 8'h33, 3'd0, 0, 0);
    cycle(0, 0, 0, 1, 0, 1, 1, 8'h99, 8'h00);
    check_state("ret_wins", 8'h33, 3'd0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1, 0, 8'h70, 8'h00);
    check_state("call_after", 8'h70, 3'd1, 0, 1);
    cycle(0, 1, 0, 0, 0, 0, 1, 8'h00, 8'h00);
    check_state("stall_ret", 8'h70, 3'd1, 0, 1);

    // lower-priority arbitration
    cycle(0, 0, 1, 1, 1, 0, 0, 8'h60, 8'h10);
    check("load_wins", 32'(pc_out), 32'h60);
    cycle(0, 0, 0, 1, 1, 0, 0, 8'h00, 8'h10);
    check("branch_wins", 32'(pc_out), 32'h70);
    cycle(0, 0, 1, 0, 0, 1, 0, 8'h05, 8'h00);
    check_state("call_wins", 8'h05, 3'd2, 0, 1);
    cycle(0, 0, 0, 0, 0, 1, 1, 8'hEE, 8'h00);
    check_state("ret_over_call", 8'h71, 3'd1, 0, 1);
    cycle(0, 0, 0, 0, 0, 1, 0, 8'h05, 8'h00);
    check_state("recall", 8'h05, 3'd2, 0, 1);

    // reset overrides call and stall mid-stack
    cycle(1, 1, 0, 0, 0, 1, 0, 8'hAA, 8'h00);
    check_state("reset_call", 8'h00, 3'd0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00);
    check_state("post_reset_ret", 8'h00, 3'd0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_stack_unit.md
PC_STACK_UNIT -- requirements
Module: pc_stack_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter WIDTH, default 8, SHALL set the PC width in bits (WIDTH >= 2).
REQ-003 Parameter DEPTH, default 4, SHALL set the number of return-address stack entries (DEPTH >= 1).
REQ-004 Parameter RESET_VEC, default 0, SHALL set the PC value loaded on reset.
REQ-005 Port clk  input  1  SHALL be the clock; all state updates occur on its rising edge.
REQ-006 Port reset  input  1  SHALL be the synchronous, active-high reset.
REQ-007 Port stall  input  1  SHALL freeze all state when high.
REQ-008 Port load_pc  input  1  SHALL request an absolute jump to pc_in.
REQ-009 Port inc_pc  input  1  SHALL request a sequential increment.
REQ-010 Port branch_rel  input  1  SHALL request a relative branch by offset.
REQ-011 Port call  input  1  SHALL request a push of the return address and a jump to pc_in.
REQ-012 Port ret  input  1  SHALL request a pop of the stack top into the PC.
REQ-013 Port pc_in  input  WIDTH  SHALL carry the jump and call target.
REQ-014 Port offset  input  WIDTH  SHALL carry the two's-complement branch displacement.
REQ-015 Port pc_out  output  WIDTH  SHALL carry the registered program counter.
REQ-016 Port sp  output  $clog2(DEPTH+1)  SHALL carry the number of valid stack entries.
REQ-017 Ports stack_full and stack_empty  output  1 each  SHALL be high when sp==DEPTH and when sp==0, respectively.
REQ-018 Ports overflow_err and underflow_err  output  1 each  SHALL be sticky error flags.

Function
REQ-019 Only one operation SHALL take effect per cycle, chosen by fixed priority: reset > stall > ret > call > load_pc > branch_rel > inc_pc.
REQ-020 When no request is active, pc_out and the stack SHALL hold their values.
REQ-021 inc_pc SHALL set pc_out <= pc_out+1 modulo 2^WIDTH, so all-ones wraps to 0.
REQ-022 branch_rel SHALL set pc_out <= pc_out+offset modulo 2^WIDTH, with offset treated as signed.
REQ-023 load_pc SHALL set pc_out <= pc_in.
REQ-024 call with sp<DEPTH SHALL, in the same cycle: write (pc_out+1) mod 2^WIDTH to entry sp, increment sp, and set pc_out <= pc_in.
REQ-025 call with sp==DEPTH SHALL leave pc_out, sp and the stack unchanged and set overflow_err.
REQ-026 ret with sp>0 SHALL set pc_out <= entry sp-1 and decrement sp.
REQ-027 ret with sp==0 SHALL leave pc_out and sp unchanged and set underflow_err.
REQ-028 A rejected call or ret SHALL NOT fall through to a lower-priority request in the same cycle.
REQ-029 The stack SHALL be LIFO, so nested calls return in reverse order.
REQ-030 Every output SHALL be registered or decoded only from sp, with one-cycle latency from request to visible pc_out and sp.
REQ-031 When stall is high, no state SHALL change, including the error flags, regardless of the other inputs.
REQ-032 Once set, overflow_err and underflow_err SHALL remain high until reset.

Reset
REQ-033 A reset sampled high SHALL, at that edge, set pc_out=RESET_VEC, sp=0, stack_empty=1, stack_full=0, overflow_err=0 and underflow_err=0.
REQ-034 Reset SHALL override stall and every request in the same cycle, including a reset asserted mid-call or mid-ret.
REQ-035 Stack entry contents SHALL NOT require reset, since they are unreachable while sp=0.

Verification
REQ-036 Reset, then inc_pc for 256 cycles (WIDTH=8) -> pc_out steps 0,1,...,255 and returns to 0; no error flag set.
REQ-037 pc_out=0x10, branch_rel with offset=0xFC -> pc_out=0x0C; then offset=0x05 -> pc_out=0x11.
REQ-038 With pc_out=0x20: call pc_in=0x80; at 0x80, call pc_in=0xA0; ret; ret -> pc_out sequence 0x80, 0xA0, 0x81, 0x21, and sp sequence 1, 2, 1, 0.
REQ-039 DEPTH=4: 5 calls -> sp=4, stack_full=1, overflow_err=1, pc_out holds the 4th target; 4 rets then 1 more ret -> underflow_err=1, pc_out holds.
REQ-040 call, ret and inc_pc all high with stall=1 -> no change; drop stall -> ret wins (underflow_err=1 if sp==0).
REQ-041 Reset asserted together with call while sp=2 -> pc_out=RESET_VEC, sp=0, both error flags cleared next cycle.
